// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam int unsigned WordWidth      = 16;
  localparam int unsigned DefaultLatency = 2;
  // LATENCY is limited to 1..15, so the countdown only needs 4 bits.
  localparam int unsigned CntWidth       = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/imem_array.sv
// Word storage: synchronous write port, combinational read port, no reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [WordWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [WordWidth-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrWidth;

  logic [WordWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder: accepts a request, stalls fetch while the
// countdown runs, then pulses done with the captured word (or zero on a misaligned address).
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned LATENCY    = DefaultLatency,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [15:0]           addr,
  output logic                  stall,
  output logic                  done,
  output logic [WordWidth-1:0]  data_out,
  output logic                  err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [WordWidth-1:0]  ld_data
);

  localparam logic [CntWidth-1:0] CntInit = CntWidth'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [WordWidth-1:0]  word_q, word_d;
  logic                  err_q, err_d;
  logic [WordWidth-1:0]  dout_q;
  logic                  accept;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [WordWidth-1:0]  rd_word;
  logic                  unused_addr;

  // Byte address -> word index; bits above the array depth wrap.
  assign rd_idx      = addr[DEPTH_LOG2:1];
  assign unused_addr = ^addr;

  imem_array #(
    .AddrWidth (DEPTH_LOG2)
  ) u_imem_array (
    .clk_i   (clk),
    .we_i    (ld_en),
    .waddr_i (ld_addr),
    .wdata_i (ld_data),
    .raddr_i (rd_idx),
    .rdata_o (rd_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    err_d   = err_q;
    accept  = req && ((state_q == StIdle) || (state_q == StResp));

    unique case (state_q)
      StIdle: ;
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntWidth'(1)) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Word is captured at acceptance, so later loads cannot disturb it (read-before-write).
    if (accept) begin
      word_d  = rd_word;
      err_d   = addr[0];
      cnt_d   = CntInit;
      state_d = (CntInit == '0) ? StResp : StWait;
    end
  end

  always_comb begin
    done     = (state_q == StResp);
    stall    = (state_q == StWait);
    err      = done & err_q;
    data_out = done ? (err_q ? '0 : word_q) : dout_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      err_q   <= err_d;
      dout_q  <= data_out;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench: one instance at LATENCY=2 for the directed cases, one at LATENCY=1
// for back-to-back streaming.
module tb_imem_responder;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_a, stall_a, done_a, err_a, ld_en_a;
  logic [15:0] addr_a, dout_a, ld_data_a;
  logic [7:0]  ld_addr_a;
  logic        req_b, stall_b, done_b, err_b, ld_en_b;
  logic [15:0] addr_b, dout_b, ld_data_b;
  logic [7:0]  ld_addr_b;

  logic [15:0] shadow_a [256];
  logic [15:0] shadow_b [256];
  exp_t        exp_a [$];
  exp_t        exp_b [$];

  int n_tests = 0;
  int n_fail  = 0;

  imem_responder #(.LATENCY(2), .DEPTH_LOG2(8)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .req      (req_a),
    .addr     (addr_a),
    .stall    (stall_a),
    .done     (done_a),
    .data_out (dout_a),
    .err      (err_a),
    .ld_en    (ld_en_a),
    .ld_addr  (ld_addr_a),
    .ld_data  (ld_data_a)
  );

  imem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .req      (req_b),
    .addr     (addr_b),
    .stall    (stall_b),
    .done     (done_b),
    .data_out (dout_b),
    .err      (err_b),
    .ld_en    (ld_en_b),
    .ld_addr  (ld_addr_b),
    .ld_data  (ld_data_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_a(input logic [7:0] a, input logic [15:0] d);
    ld_en_a = 1'b1; ld_addr_a = a; ld_data_a = d;
    @(posedge clk); #1;
    ld_en_a = 1'b0;
    shadow_a[a] = d;
  endtask

  task automatic load_b(input logic [7:0] a, input logic [15:0] d);
    ld_en_b = 1'b1; ld_addr_b = a; ld_data_b = d;
    @(posedge clk); #1;
    ld_en_b = 1'b0;
    shadow_b[a] = d;
  endtask

  task automatic push_a(input logic [15:0] ad);
    exp_t e;
    e.err  = ad[0];
    e.data = ad[0] ? 16'h0000 : shadow_a[ad[8:1]];
    exp_a.push_back(e);
  endtask

  // Drive one request for one edge; expectation is recorded at stimulus time.
  task automatic issue_a(input logic [15:0] ad);
    req_a = 1'b1; addr_a = ad;
    push_a(ad);
    @(posedge clk); #1;
    req_a = 1'b0;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 20; i++) begin
      if (exp_a.size() == 0) break;
      @(negedge clk); #1;
    end
    check("a_drain", exp_a.size(), 0);
  endtask

  task automatic drain_b();
    for (int i = 0; i < 20; i++) begin
      if (exp_b.size() == 0) break;
      @(negedge clk); #1;
    end
    check("b_drain", exp_b.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done_a) begin
      if (exp_a.size() == 0) begin
        check("a_unexpected_done", 1, 0);
      end else begin
        e = exp_a.pop_front();
        check("a_data", dout_a, e.data);
        check("a_err", err_a, e.err);
      end
    end
    check("a_err_only_with_done", err_a & ~done_a, 0);
    if (done_b) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected_done", 1, 0);
      end else begin
        e = exp_b.pop_front();
        check("b_data", dout_b, e.data);
        check("b_err", err_b, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    req_a = 1'b0; addr_a = '0; ld_en_a = 1'b0; ld_addr_a = '0; ld_data_a = '0;
    req_b = 1'b0; addr_b = '0; ld_en_b = 1'b0; ld_addr_b = '0; ld_data_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall_a, 0);
    check("rst_done", done_a, 0);
    check("rst_data", dout_a, 16'h0000);
    check("rst_err", err_a, 0);
    check("rst_done_b", done_b, 0);
    rst = 1'b1;

    load_a(8'd3, 16'hA5C3);
    load_a(8'd5, 16'h1111);

    // Basic LATENCY=2 timing: stall in N+1, done in N+2, then data holds.
    issue_a(16'h0006);
    @(negedge clk);
    check("lat2_stall_n1", stall_a, 1);
    check("lat2_done_n1", done_a, 0);
    @(negedge clk);
    check("lat2_done_n2", done_a, 1);
    check("lat2_stall_n2", stall_a, 0);
    check("lat2_data_n2", dout_a, 16'hA5C3);
    @(negedge clk);
    check("hold_done", done_a, 0);
    check("hold_data", dout_a, 16'hA5C3);
    drain_a();

    // Misaligned address, then an aligned one.
    issue_a(16'h0007);
    drain_a();
    check("misaligned_data_zero", dout_a, 16'h0000);
    issue_a(16'h0006);
    drain_a();

    // Load and request to the same word in one cycle returns the old data.
    ld_en_a = 1'b1; ld_addr_a = 8'd5; ld_data_a = 16'h2222;
    req_a = 1'b1; addr_a = 16'h000A;
    push_a(16'h000A);
    @(posedge clk); #1;
    ld_en_a = 1'b0; req_a = 1'b0;
    shadow_a[5] = 16'h2222;
    drain_a();
    issue_a(16'h000A);
    drain_a();

    // Request during WAIT is dropped.
    issue_a(16'h0006);
    req_a = 1'b1; addr_a = 16'h000A;
    @(posedge clk); #1;
    req_a = 1'b0;
    drain_a();
    repeat (3) begin
      @(negedge clk);
      check("wait_req_ignored", done_a, 0);
    end

    // Reset mid-WAIT aborts with no done; storage survives.
    req_a = 1'b1; addr_a = 16'h0006;
    @(posedge clk); #1;
    req_a = 1'b0;
    @(negedge clk);
    check("abort_in_wait", stall_a, 1);
    #1 rst = 1'b0;
    #1;
    check("abort_stall", stall_a, 0);
    check("abort_done", done_a, 0);
    check("abort_data", dout_a, 16'h0000);
    check("abort_err", err_a, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done_a, 0);
    end
    issue_a(16'h0006);
    drain_a();
    issue_a(16'h000A);
    drain_a();

    // LATENCY=1 streaming: req held high, done every cycle, never stalls.
    load_b(8'd0, 16'h1234);
    load_b(8'd1, 16'hBEEF);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      req_b  = 1'b1;
      addr_b = (i % 2 == 1) ? 16'h0002 : 16'h0000;
      e.data = shadow_b[i % 2];
      e.err  = 1'b0;
      exp_b.push_back(e);
      @(posedge clk);
      @(negedge clk);
      check("b_done_every_cycle", done_b, 1);
      check("b_no_stall", stall_b, 0);
    end
    req_b = 1'b0;
    drain_b();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to done; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the number of 16-bit words stored.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, 1 bit: fetch-side read request.
REQ-006 SHALL have port addr, input, 16 bits: byte address of the requested instruction.
REQ-007 SHALL have port stall, output, 1 bit: responder busy, fetch holds PC.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse, data_out/err valid.
REQ-009 SHALL have port data_out, output, 16 bits: returned instruction word.
REQ-010 SHALL have port err, output, 1 bit: misaligned-address flag, valid with done.
REQ-011 SHALL have ports ld_en (input, 1), ld_addr (input, DEPTH_LOG2), ld_data (input, 16): word-addressed preload write port.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-013 SHALL accept req only in IDLE or RESP; req in WAIT is ignored, with no queuing.
REQ-014 On acceptance, SHALL capture word index addr[DEPTH_LOG2:1], with upper address bits ignored (wrap), read the word that cycle, and capture err = addr[0].
REQ-015 On acceptance, SHALL load a countdown with LATENCY-1; go to RESP if 0, else WAIT.
REQ-016 In WAIT, SHALL decrement the counter each cycle and go to RESP on the cycle the counter reaches 0.
REQ-017 SHALL make done high exactly during RESP, so request accepted at edge N gives done in cycle N+LATENCY.
REQ-018 From RESP, SHALL go to WAIT/RESP if req is accepted that cycle (back-to-back), else IDLE.
REQ-019 SHALL make stall equal (state==WAIT).
REQ-020 SHALL set data_out to the captured word when done and err=0; SHALL set data_out to 0x0000 when err=1; SHALL hold data_out at its last value otherwise.
REQ-021 SHALL make err high only with done.
REQ-022 SHALL write ld_data to ld_addr synchronously when ld_en is high, in any state.
REQ-023 On a same-cycle ld_en and accepted req to the same word, SHALL return the old data (read-before-write).
REQ-024 SHALL not let a load after acceptance alter an in-flight response.

Reset
REQ-025 rst low SHALL immediately force IDLE, counter 0, done 0, err 0, stall 0, data_out 0x0000.
REQ-026 Reset mid-WAIT SHALL abort the request, with no done pulse.
REQ-027 SHALL not clear storage contents on reset.

Structure
REQ-028 SHALL place the state enum, word width 16, and default LATENCY in shared package imem_pkg.
REQ-029 SHALL instantiate one sub-module, imem_array: storage with synchronous write and combinational read.
REQ-030 SHALL keep all handshake/FSM logic in imem_responder.

Verification
REQ-031 Preload word 3 = 0xA5C3, LATENCY=2, req with addr=0x0006 at edge N -> stall high cycle N+1, done+data_out=0xA5C3 cycle N+2, err=0.
REQ-032 req held high continuously, addrs 0x0000/0x0002, LATENCY=1 -> done every cycle, data in order, stall never high.
REQ-033 addr=0x0007 -> done with err=1, data_out=0x0000; next aligned request returns correct data with err=0.
REQ-034 rst low during WAIT -> outputs zero immediately, no done; request after release completes normally, preloaded contents intact.
REQ-035 ld_en to word 5 (0x1111->0x2222) in same cycle as req addr=0x000A -> returns 0x1111; repeat request returns 0x2222.
REQ-036 req pulsed during WAIT with a different addr -> ignored; only the original request completes.
